sa_feeder: RTL
==============

// Module: sa_feeder
// PURPOSE
//  Drives the top/left edge of the ROWS x COLS weight-stationary pe array and sits between the operand buffers and the array.
//  Per job it sequences three phases:
//    - one-cycle accumulator clear;
//    - ROWS-deep weight preload down the columns;
//    - diagonally skewed activation streaming into the rows, followed by a zero drain so the last wavefront leaves.
// PARAMETERS
//  ROWS    4   array rows; activation lanes
//  COLS    4   array columns; weight lanes
//  DATA_W  8   activation/weight element width
//  ACC_W   8   psum width at array top edge
//  CNT_W   8   width of num_vec
// PORTS
//  clk             in   1              clock, rising edge
//  rst_n           in   1              async reset, active-low
//  start           in   1              job start pulse; sampled only in IDLE
//  num_vec         in   CNT_W          activation vectors in job; sampled with start
//  busy            out  1              high in every state except IDLE
//  done            out  1              one-cycle pulse at end of DRAIN
//  w_valid         in   1              weight-row valid
//  w_ready         out  1              weight-row ready
//  w_data          in   COLS*DATA_W    weight row; lane c = bits [c*DATA_W +: DATA_W]
//  x_valid         in   1              activation-vector valid
//  x_ready         out  1              activation-vector ready
//  x_data          in   ROWS*DATA_W    activation vector; lane r = row r
//  pe_clear        out  1              to pe clear, all PEs
//  pe_weight_load  out  1              to pe weight_load, all PEs
//  pe_weight       out  COLS*DATA_W    to weight_in of row-0 PEs
//  pe_a            out  ROWS*DATA_W    to a_in of column-0 PEs, skewed
//  pe_a_valid      out  ROWS           per-row valid, travels with pe_a
//  pe_psum         out  COLS*ACC_W     to psum_in of row-0 PEs; constant 0
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counters and skew lines 0. Async assert takes effect mid-job at once; no job resumes.
//  Registers: every pe_* output and done is registered.
//  FSM: IDLE -> CLEAR -> WLOAD -> STREAM -> DRAIN -> IDLE.
//   IDLE:   start=1 latches num_vec and goes to CLEAR. start is ignored in every other state.
//   CLEAR:  exactly 1 cycle; pe_clear=1 in the following cycle.
//   WLOAD:  w_ready=1. On each w_valid&w_ready:
//           - pe_weight <= w_data and pe_weight_load <= 1 (next cycle); otherwise pe_weight_load <= 0, so a stall holds the weights.
//           - After ROWS handshakes go to STREAM. The first row accepted ends in array row ROWS-1; the last ends in row 0.
//   STREAM: x_ready=1 while accepted < num_vec. Each cycle (see skew rule) injects one vector into the skew line:
//           - x_valid&x_ready: x_data with lane-valid 1;
//           - otherwise: zeros with lane-valid 0 (a bubble).
//           After num_vec handshakes go to DRAIN. num_vec=0 skips STREAM straight to DRAIN.
//   DRAIN:  injects zero/invalid vectors for ROWS+COLS cycles, then done=1 for 1 cycle and goes to IDLE.
//  Skew: lane r of a vector injected at cycle t appears on pe_a[r] and pe_a_valid[r] at cycle t+1+r.
//   - The skew line advances every cycle, bubbles included; the array is never stalled.
//  Handshakes:
//   - w_ready=0 outside WLOAD; x_ready=0 outside STREAM.
//   - Data is transferred only on valid&ready. Valid may rise without ready.
//  Width: data passes through unmodified; no arithmetic. pe_psum is tied to 0.
//  Counters: the weight counter is clog2(ROWS+1) bits wide. The vector counter is CNT_W bits and saturates at num_vec; no wrap.
//  Boundaries:
//   - A start arriving together with done is ignored; done is emitted from DRAIN, not IDLE.
//   - An x_valid held after the last vector sees x_ready=0.
// STRUCTURE
//  sa_pkg.vh: FSM state encodings (S_IDLE..S_DRAIN); helper localparams for lane slicing.
//  Sub-module sa_skew_line #(DEPTH, W): DEPTH-stage data+valid delay line with async clear.
//   - Lane r instantiates DEPTH=r+1. DEPTH=1 is a single register.
//  The top level holds the FSM, the counters and the generate loop over the lanes.
// TESTING
//  1. Reset mid-STREAM: drop rst_n -> same cycle, busy, pe_* and done are 0 and pe_a_valid is 0. After release, start works normally.
//  2. Full job, ROWS=COLS=4, num_vec=3, back-to-back valids, weights 5,6,7,8 per row:
//     - pe_clear is high for 1 cycle.
//     - pe_weight_load is high for 4 consecutive cycles carrying 5,6,7,8.
//     - done fires exactly 4+3+8 cycles after WLOAD entry.
//  3. Skew check: vector x={4,3,2,1} (lane0=1) accepted at cycle T -> pe_a[0]=1 at T+1, pe_a[1]=2 at T+2, pe_a[2]=3 at T+3, pe_a[3]=4 at T+4.
//  4. Stall: drop w_valid for 2 cycles mid-WLOAD -> pe_weight_load=0 in those cycles; still exactly 4 loads.
//     Drop x_valid for 1 cycle -> a zero bubble with pe_a_valid=0 moves diagonally through the lanes.
//  5. num_vec=0 -> CLEAR, 4 weight loads, no x_ready, DRAIN of 8 cycles, done.
//  6. A start pulse during STREAM is ignored: num_vec is not re-latched and exactly one done is produced.

Source files
------------

// File: rtl/sa_feeder_pkg.sv
// Shared types for the systolic-array edge feeder: controller state encoding
// and a lane-slicing helper used by the top level.
package sa_feeder_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_WLOAD  = 3'd2,
        S_STREAM = 3'd3,
        S_DRAIN  = 3'd4
    } state_t;

    // LSB position of lane 'lane' in a packed bus of 'w'-bit lanes.
    function automatic int lane_lsb(input int lane, input int w);
        return lane * w;
    endfunction

endpackage

// File: rtl/sa_feeder_skew_line.sv
// DEPTH-stage data+valid delay line; one instance per activation lane gives
// the diagonal wavefront skew. Stage 0 captures the input, the last stage drives out.
module sa_skew_line #(
    parameter int DEPTH = 1,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic [W-1:0] out_data,
    output logic         out_valid
);

    logic [W-1:0]     data_q  [DEPTH];
    logic [W-1:0]     data_d  [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;

    always_comb begin
        data_d[0]  = in_data;
        valid_d    = '0;
        valid_d[0] = in_valid;
        for (int i = 1; i < DEPTH; i++) begin
            data_d[i]  = data_q[i-1];
            valid_d[i] = valid_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q[DEPTH-1];
    assign out_valid = valid_q[DEPTH-1];

endmodule

// File: rtl/sa_feeder.sv
// Edge feeder for a ROWS x COLS weight-stationary array: per job it clears the
// accumulators, preloads ROWS weight rows, streams skewed activations, then drains.
//
// state    | meaning
// S_IDLE   | waiting for start; num_vec latched on start
// S_CLEAR  | single cycle; schedules pe_clear for the next cycle
// S_WLOAD  | w_ready high; ROWS weight rows accepted, each pulses pe_weight_load
// S_STREAM | x_ready high until num_vec vectors accepted; bubbles injected on stalls
// S_DRAIN  | ROWS+COLS zero injections, then one cycle with done high
module sa_feeder
    import sa_feeder_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 8,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [CNT_W-1:0]         num_vec,
    output logic                     busy,
    output logic                     done,
    input  logic                     w_valid,
    output logic                     w_ready,
    input  logic [COLS*DATA_W-1:0]   w_data,
    input  logic                     x_valid,
    output logic                     x_ready,
    input  logic [ROWS*DATA_W-1:0]   x_data,
    output logic                     pe_clear,
    output logic                     pe_weight_load,
    output logic [COLS*DATA_W-1:0]   pe_weight,
    output logic [ROWS*DATA_W-1:0]   pe_a,
    output logic [ROWS-1:0]          pe_a_valid,
    output logic [COLS*ACC_W-1:0]    pe_psum
);

    localparam int WC_W = $clog2(ROWS + 1);
    localparam int DC_W = $clog2(ROWS + COLS + 1);
    localparam logic [WC_W-1:0] W_LAST    = WC_W'(ROWS - 1);
    localparam logic [DC_W-1:0] D_LAST    = DC_W'(ROWS + COLS - 1);
    localparam logic [DC_W-1:0] D_DONE    = DC_W'(ROWS + COLS);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        num_vec_q, num_vec_d;
    logic [CNT_W-1:0]        v_cnt_q, v_cnt_d;
    logic [CNT_W-1:0]        v_next;
    logic [WC_W-1:0]         w_cnt_q, w_cnt_d;
    logic [DC_W-1:0]         d_cnt_q, d_cnt_d;
    logic                    pe_clear_q, pe_clear_d;
    logic                    pe_weight_load_q, pe_weight_load_d;
    logic [COLS*DATA_W-1:0]  pe_weight_q, pe_weight_d;
    logic                    done_q, done_d;
    logic [ROWS*DATA_W-1:0]  inj_data;
    logic                    inj_valid;

    assign v_next = v_cnt_q + CNT_W'(1);

    always_comb begin
        state_d          = state_q;
        num_vec_d        = num_vec_q;
        v_cnt_d          = v_cnt_q;
        w_cnt_d          = w_cnt_q;
        d_cnt_d          = d_cnt_q;
        pe_clear_d       = 1'b0;
        pe_weight_load_d = 1'b0;
        pe_weight_d      = pe_weight_q;
        done_d           = 1'b0;
        inj_data         = '0;
        inj_valid        = 1'b0;
        w_ready          = 1'b0;
        x_ready          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_vec_d = num_vec;
                    v_cnt_d   = '0;
                    w_cnt_d   = '0;
                    d_cnt_d   = '0;
                    state_d   = S_CLEAR;
                end
            end
            S_CLEAR: begin
                pe_clear_d = 1'b1;
                state_d    = S_WLOAD;
            end
            S_WLOAD: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    pe_weight_d      = w_data;
                    pe_weight_load_d = 1'b1;
                    if (w_cnt_q == W_LAST) begin
                        w_cnt_d = '0;
                        state_d = (num_vec_q == '0) ? S_DRAIN : S_STREAM;
                    end else begin
                        w_cnt_d = w_cnt_q + WC_W'(1);
                    end
                end
            end
            S_STREAM: begin
                x_ready = (v_cnt_q < num_vec_q);
                if (!x_ready) begin
                    state_d = S_DRAIN;
                end else if (x_valid) begin
                    inj_data  = x_data;
                    inj_valid = 1'b1;
                    v_cnt_d   = v_next;
                    if (v_next == num_vec_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // done rides in the extra DRAIN cycle so a coincident start is ignored
                if (d_cnt_q == D_DONE) begin
                    d_cnt_d = '0;
                    state_d = S_IDLE;
                end else begin
                    d_cnt_d = d_cnt_q + DC_W'(1);
                end
                done_d = (d_cnt_q == D_LAST);
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            num_vec_q        <= '0;
            v_cnt_q          <= '0;
            w_cnt_q          <= '0;
            d_cnt_q          <= '0;
            pe_clear_q       <= 1'b0;
            pe_weight_load_q <= 1'b0;
            pe_weight_q      <= '0;
            done_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            num_vec_q        <= num_vec_d;
            v_cnt_q          <= v_cnt_d;
            w_cnt_q          <= w_cnt_d;
            d_cnt_q          <= d_cnt_d;
            pe_clear_q       <= pe_clear_d;
            pe_weight_load_q <= pe_weight_load_d;
            pe_weight_q      <= pe_weight_d;
            done_q           <= done_d;
        end
    end

    // Lane r is delayed r+1 cycles so vectors enter the array as a diagonal wavefront.
    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        localparam int LSB = lane_lsb(r, DATA_W);
        sa_skew_line #(
            .DEPTH (r + 1),
            .W     (DATA_W)
        ) u_skew (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_data   (inj_data[LSB +: DATA_W]),
            .in_valid  (inj_valid),
            .out_data  (pe_a[LSB +: DATA_W]),
            .out_valid (pe_a_valid[r])
        );
    end

    assign busy           = (state_q != S_IDLE);
    assign done           = done_q;
    assign pe_clear       = pe_clear_q;
    assign pe_weight_load = pe_weight_load_q;
    assign pe_weight      = pe_weight_q;
    assign pe_psum        = '0;

endmodule
